// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, captures {pc, instr} from a combinational-read
// instruction memory into a small FIFO, and hands entries to decode.
// Optional performance counters are enabled with `define FETCH_QUEUE_PERF_EN.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshake: an entry transfers to decode on a rising edge where out_valid and
  // out_ready are both 1; out_valid never depends on out_ready or imem_instr.

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        pop;
  logic        push;
  logic        full;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_target     = {redirect_pc[31:2], 2'b00};

  assign full = (count_q == FULL);
  assign pop  = out_valid & out_ready;
  // A full queue still accepts the new word when the head leaves in the same cycle.
  assign push = !redirect_valid & (!full | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        instr_mem_q[wr_ptr_q] <= imem_instr;
      end
    end
  end

  assign imem_pc      = fetch_pc_q;
  assign out_valid    = (count_q != '0);
  assign out_pc       = pc_mem_q[rd_ptr_q];
  assign out_instr    = instr_mem_q[rd_ptr_q];
  assign out_pc_plus4 = out_pc + 32'd4;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (full && !pop && !redirect_valid) perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_valid) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random ready/redirect/reset
// traffic, checked against a queue-based model of the fetch stage.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  // Instruction memory: word 0 is a NOP, other words a scrambled function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1357} + 32'h0000_0013;
  endfunction

  assign imem_instr = mem_word(imem_pc);

  // ---------------- scoreboard / model ----------------
  logic [63:0] exp_q[$];        // {pc, instr} of entries waiting for decode
  logic [31:0] model_pc;
  logic [31:0] m_fetched, m_stall, m_flush;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check32("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
    check32("imem_pc", imem_pc, model_pc);
    if (exp_q.size() != 0) begin
      check32("out_pc", out_pc, exp_q[0][63:32]);
      check32("out_instr", out_instr, exp_q[0][31:0]);
      check32("out_pc_plus4", out_pc_plus4, exp_q[0][63:32] + 32'd4);
    end
`ifdef FETCH_QUEUE_PERF_EN
    check32("perf_fetched", perf_fetched, m_fetched);
    check32("perf_stall", perf_stall, m_stall);
    check32("perf_flush", perf_flush, m_flush);
`endif
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, advance the model, cross the rising edge,
  // then compare at the next falling edge.
  task automatic step(input logic rst, input logic rdy, input logic redir, input logic [31:0] tgt);
    logic do_pop, do_push;
    rst_n          = rst;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    if (!rst) begin
      exp_q.delete();
      model_pc  = RESET_PC;
      m_fetched = 0;
      m_stall   = 0;
      m_flush   = 0;
    end else begin
      do_pop  = (exp_q.size() != 0) && rdy;
      do_push = !redir && ((exp_q.size() < DEPTH) || do_pop);
      if (exp_q.size() == DEPTH && !do_pop && !redir) m_stall++;
      if (do_pop) void'(exp_q.pop_front());
      if (redir) begin
        exp_q.delete();
        model_pc = {tgt[31:2], 2'b00};
        m_flush++;
      end else if (do_push) begin
        exp_q.push_back({model_pc, mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
        m_fetched++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    exp_q.delete(); model_pc = RESET_PC; m_fetched = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);

    // Reset state
    check32("rst_valid", {31'b0, out_valid}, 32'd0);
    check32("rst_instr", out_instr, 32'd0);
    check32("rst_pc", out_pc, 32'd0);
    check32("rst_pc_plus4", out_pc_plus4, 32'd4);
    check32("rst_imem_pc", imem_pc, RESET_PC);

    // First instruction one cycle later, then streaming
    step(1'b1, 1'b1, 1'b0, '0);
    check32("first_instr", out_instr, 32'h0000_0013);
    check32("first_pc", out_pc, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Back-pressure from reset: queue fills, fetch PC freezes
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
    check32("frozen_imem_pc", imem_pc, 32'h8);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    check32("pre_redirect_head", out_pc, 32'h8);

    // Redirect while holding 8,12: 8 is consumed, 12 is dropped
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    check32("redir_valid", {31'b0, out_valid}, 32'd0);
    check32("redir_imem_pc", imem_pc, 32'h100);
    step(1'b1, 1'b1, 1'b0, '0);
    check32("redir_target_pc", out_pc, 32'h100);

    // PC wrap at the top of the address space
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b0, '0);
    check32("wrap_pc", out_pc, 32'hFFFF_FFFC);
    check32("wrap_plus4", out_pc_plus4, 32'h0);
    step(1'b1, 1'b1, 1'b0, '0);
    check32("wrap_next_pc", out_pc, 32'h0);

    // Back-to-back redirects: only the last target is fetched
    step(1'b1, 1'b1, 1'b1, 32'h0000_2000);
    step(1'b1, 1'b1, 1'b1, 32'h0000_3000);
    step(1'b1, 1'b1, 1'b0, '0);
    check32("b2b_pc", out_pc, 32'h3000);

    // Reset with full queue and simultaneous redirect
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_4444);
    check32("rst_over_redir_pc", imem_pc, RESET_PC);
    check32("rst_over_redir_valid", {31'b0, out_valid}, 32'd0);

    // Perf scenario: 10 streaming, 1 filling + 3 stalled, 1 redirect
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040);
`ifdef FETCH_QUEUE_PERF_EN
    check32("perf_stall_plan", perf_stall, 32'd3);
    check32("perf_flush_plan", perf_flush, 32'd1);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_rdy, r_redir;
      logic [31:0] r_tgt;
      r_rst   = ($urandom_range(0, 199) != 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_redir = ($urandom_range(0, 11) == 0);
      r_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
      step(r_rst, r_rdy, r_redir, r_tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
